// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID/EX hazard inputs, dmem handshake and
// pipeline-register controls exchanged with the stall sequencer.
interface hazard_stall_controller_if;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_rt_addr;
   logic        ex_branch_taken;
   logic        ex_jump;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_write_en;
   logic        if_id_write_en;
   logic        if_id_flush;
   logic        id_ex_write_en;
   logic        id_ex_flush;
   logic        ex_mem_write_en;
   logic        stall_active;
   logic [1:0]  ctrl_state;
   logic        mem_timeout;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   modport master (
      input  id_rs_addr, id_rt_addr, id_uses_rt,
      input  ex_mem_read, ex_rt_addr,
      input  ex_branch_taken, ex_jump,
      input  dmem_req, dmem_ready,
      output pc_write_en, if_id_write_en, if_id_flush,
      output id_ex_write_en, id_ex_flush, ex_mem_write_en,
      output stall_active, ctrl_state, mem_timeout,
      output perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      output id_rs_addr, id_rt_addr, id_uses_rt,
      output ex_mem_read, ex_rt_addr,
      output ex_branch_taken, ex_jump,
      output dmem_req, dmem_ready,
      input  pc_write_en, if_id_write_en, if_id_flush,
      input  id_ex_write_en, id_ex_flush, ex_mem_write_en,
      input  stall_active, ctrl_state, mem_timeout,
      input  perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use / redirect / dmem-wait stall sequencer.
// Perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int MEM_TIMEOUT       = 255
) (
   input logic clk,
   input logic rst,
   hazard_stall_controller_if.master hz
);
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_MEM   = 2'd3;

   localparam logic [7:0] LOAD_RLD  = 8'(LOAD_STALL_CYCLES - 1);
   localparam logic [7:0] FLUSH_RLD = 8'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);

   logic [1:0] state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       timeout_q;
   logic       load_use, redirect, mem_busy;
   logic       c_mem, c_red, c_fl, c_ld;
   logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
   logic       if_id_fl, id_ex_fl, stall;

   assign load_use = hz.ex_mem_read
                   && hz.ex_rt_addr != 5'd0
                   && (hz.ex_rt_addr == hz.id_rs_addr
                       || (hz.id_uses_rt
                           && hz.ex_rt_addr == hz.id_rt_addr));
   assign redirect = hz.ex_branch_taken | hz.ex_jump;
   assign mem_busy = hz.dmem_req & ~hz.dmem_ready;

   // In MEM_WAIT only dmem_ready matters; the release cycle skips rule 1.
   assign c_mem = (state == S_MEM) ? !hz.dmem_ready : mem_busy;
   assign c_red = !c_mem && redirect;
   assign c_fl  = !c_mem && !redirect && state == S_FLUSH;
   assign c_ld  = !c_mem && !redirect && state != S_FLUSH
                && (load_use || state == S_LOAD);

   always_comb begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      if_id_fl  = 1'b0;
      id_ex_fl  = 1'b0;
      state_nxt = S_RUN;
      cnt_nxt   = 8'd0;
      unique case (1'b1)
         c_mem: begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            state_nxt = S_MEM;
            if (state != S_MEM)
               cnt_nxt = 8'd1;
            else if (cnt == 8'hff)
               cnt_nxt = cnt;
            else
               cnt_nxt = cnt + 8'd1;
         end
         c_red: begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
            if (FLUSH_CYCLES > 1) begin
               state_nxt = S_FLUSH;
               cnt_nxt   = FLUSH_RLD;
            end
         end
         c_fl: begin
            if_id_fl = 1'b1;
            if (cnt > 8'd1) begin
               state_nxt = S_FLUSH;
               cnt_nxt   = cnt - 8'd1;
            end
         end
         c_ld: begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
            if (state == S_LOAD) begin
               if (cnt > 8'd1) begin
                  state_nxt = S_LOAD;
                  cnt_nxt   = cnt - 8'd1;
               end
            end else if (LOAD_STALL_CYCLES > 1) begin
               state_nxt = S_LOAD;
               cnt_nxt   = LOAD_RLD;
            end
         end
         default: begin
            state_nxt = S_RUN;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         cnt       <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_q
                    | (state_nxt == S_MEM && cnt_nxt >= TMO);
      end
   end

   assign stall = ~(pc_we & if_id_we & id_ex_we & ex_mem_we)
                | if_id_fl | id_ex_fl;

   assign hz.pc_write_en     = rst & pc_we;
   assign hz.if_id_write_en  = rst & if_id_we;
   assign hz.id_ex_write_en  = rst & id_ex_we;
   assign hz.ex_mem_write_en = rst & ex_mem_we;
   assign hz.if_id_flush     = rst & if_id_fl;
   assign hz.id_ex_flush     = rst & id_ex_fl;
   assign hz.stall_active    = rst & stall;
   assign hz.ctrl_state      = state;
   assign hz.mem_timeout     = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (c_red)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign hz.perf_stall_cnt = stall_cnt_q;
   assign hz.perf_flush_cnt = flush_cnt_q;
`else
   assign hz.perf_stall_cnt = 32'd0;
   assign hz.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed vectors on a default instance (a)
// and a LOAD=3 / FLUSH=2 / TIMEOUT=3 instance (b).
module tb_hazard_stall_controller;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_stall_controller_if ia ();
   hazard_stall_controller_if ib ();

   hazard_stall_controller u_a (
      .clk(clk), .rst(rst), .hz(ia)
   );

   hazard_stall_controller #(
      .LOAD_STALL_CYCLES(3),
      .FLUSH_CYCLES(2),
      .MEM_TIMEOUT(3)
   ) u_b (
      .clk(clk), .rst(rst), .hz(ib)
   );

   // {pc, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, stall}
   localparam logic [6:0] RUNO = 7'b1111_00_0;
   localparam logic [6:0] LDO  = 7'b0011_01_1;
   localparam logic [6:0] RDO  = 7'b1111_11_1;
   localparam logic [6:0] FLO  = 7'b1111_10_1;
   localparam logic [6:0] MWO  = 7'b0000_00_1;
   localparam logic [6:0] RSTO = 7'b0000_00_0;

`ifdef HAZARD_PERF_CNT_EN
   localparam int PF_FLUSH = 1;
   localparam int PF_STALL = 3;
`else
   localparam int PF_FLUSH = 0;
   localparam int PF_STALL = 0;
`endif

   logic [6:0] ca, cb;
   assign ca = {ia.pc_write_en, ia.if_id_write_en,
                ia.id_ex_write_en, ia.ex_mem_write_en,
                ia.if_id_flush, ia.id_ex_flush, ia.stall_active};
   assign cb = {ib.pc_write_en, ib.if_id_write_en,
                ib.id_ex_write_en, ib.ex_mem_write_en,
                ib.if_id_flush, ib.id_ex_flush, ib.stall_active};

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr,
                      input logic [4:0] er, input logic br,
                      input logic jp, input logic rq,
                      input logic rd);
      ia.id_rs_addr = rs;   ib.id_rs_addr = rs;
      ia.id_rt_addr = rt;   ib.id_rt_addr = rt;
      ia.id_uses_rt = ur;   ib.id_uses_rt = ur;
      ia.ex_mem_read = mr;  ib.ex_mem_read = mr;
      ia.ex_rt_addr = er;   ib.ex_rt_addr = er;
      ia.ex_branch_taken = br;
      ib.ex_branch_taken = br;
      ia.ex_jump = jp;      ib.ex_jump = jp;
      ia.dmem_req = rq;     ib.dmem_req = rq;
      ia.dmem_ready = rd;   ib.dmem_ready = rd;
   endtask

   task automatic idle();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #1;
      chk("rst_ctl_a", 32'(ca), 32'(RSTO));
      chk("rst_ctl_b", 32'(cb), 32'(RSTO));
      chk("rst_state", 32'(ia.ctrl_state), 32'd0);
      chk("rst_tmo", 32'(ib.mem_timeout), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // single-cycle load-use, then $0 never stalls
      drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lu_a_c0", 32'(ca), 32'(LDO));
      chk("lu_b_c0", 32'(cb), 32'(LDO));
      @(negedge clk);
      idle();
      #1;
      chk("lu_a_c1", 32'(ca), 32'(RUNO));
      chk("lu_a_st1", 32'(ia.ctrl_state), 32'd0);
      do_reset();
      drv(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lu_r0_a", 32'(ca), 32'(RUNO));
      @(negedge clk);

      // 3-cycle stall via rt on instance b
      do_reset();
      drv(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ld3_ctl%0d", k), 32'(cb),
             32'((k < 3) ? LDO : RUNO));
         chk($sformatf("ld3_st%0d", k), 32'(ib.ctrl_state),
             32'((k == 1 || k == 2) ? 1 : 0));
         @(negedge clk);
         idle();
      end
      chk("ld3_perf", ib.perf_stall_cnt, 32'(PF_STALL));
      do_reset();
      drv(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rt_unused", 32'(cb), 32'(RUNO));
      @(negedge clk);

      // jump beats load-use; FLUSH_CYCLES=2 on b
      do_reset();
      drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("jmp_a_c0", 32'(ca), 32'(RDO));
      chk("jmp_b_c0", 32'(cb), 32'(RDO));
      @(negedge clk);
      idle();
      #1;
      chk("jmp_a_c1", 32'(ca), 32'(RUNO));
      chk("jmp_b_c1", 32'(cb), 32'(FLO));
      chk("jmp_b_st1", 32'(ib.ctrl_state), 32'd2);
      @(negedge clk);
      #1;
      chk("jmp_b_c2", 32'(cb), 32'(RUNO));
      chk("jmp_b_st2", 32'(ib.ctrl_state), 32'd0);
      chk("jmp_perf_a", ia.perf_flush_cnt, 32'(PF_FLUSH));
      chk("jmp_perf_b", ib.perf_flush_cnt, 32'(PF_FLUSH));
      @(negedge clk);

      // 4-cycle memory wait released with a taken branch
      do_reset();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("mw_ctl%0d", k), 32'(ca), 32'(MWO));
         chk($sformatf("mw_st%0d", k), 32'(ia.ctrl_state),
             32'((k == 0) ? 0 : 3));
         @(negedge clk);
      end
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("mw_rel_a", 32'(ca), 32'(RDO));
      chk("mw_rel_b", 32'(cb), 32'(RDO));
      @(negedge clk);
      idle();
      #1;
      chk("mw_after_a", 32'(ca), 32'(RUNO));
      chk("mw_after_st", 32'(ia.ctrl_state), 32'd0);
      chk("mw_after_b", 32'(cb), 32'(FLO));
      chk("mw_tmo_a", 32'(ia.mem_timeout), 32'd0);
      @(negedge clk);

      // timeout after 3 wait cycles, sticky, cleared by async reset
      do_reset();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("tmo_%0d", k), 32'(ib.mem_timeout),
             32'((k == 3) ? 1 : 0));
         @(negedge clk);
      end
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("tmo_rel_ctl", 32'(cb), 32'(RUNO));
      @(negedge clk);
      idle();
      #1;
      chk("tmo_rel_st", 32'(ib.ctrl_state), 32'd0);
      chk("tmo_sticky", 32'(ib.mem_timeout), 32'd1);
      @(negedge clk);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("tmo_wait_st", 32'(ib.ctrl_state), 32'd3);
      #1;
      rst = 1'b0;
      #1;
      chk("async_st", 32'(ib.ctrl_state), 32'd0);
      chk("async_tmo", 32'(ib.mem_timeout), 32'd0);
      chk("async_ctl", 32'(cb), 32'(RSTO));
      @(negedge clk);
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
